// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_mux4.sv
// One-bit full adder built from two 4:1 muxes selected by the operand bits,
// with mux data inputs derived from the incoming carry.
module fa_mux4 (
    input  logic a_bit,
    input  logic b_bit,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic [1:0] sel;
    logic [3:0] s_data;
    logic [3:0] c_data;

    always_comb begin
        sel    = {a_bit, b_bit};
        // Index = {a,b}: sum is c for equal bits, ~c otherwise; carry is 0/c/c/1.
        s_data = {c_in, ~c_in, ~c_in, c_in};
        c_data = {1'b1, c_in, c_in, 1'b0};
        s      = s_data[sel];
        c_out  = c_data[sel];
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts a+b+cin, processes one bit per cycle LSB-first,
// and presents sum/cout/ovf after exactly WIDTH cycles with a valid/ready handshake.
module serial_adder
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic [WIDTH-1:0] acc_next;

    fa_mux4 u_fa (
        .a_bit (a_sh_q[0]),
        .b_bit (b_sh_q[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_bit)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_RUN:  busy      = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    assign acc_next = {fa_s, acc_q[WIDTH-1:1]};

    // Datapath: the visible result registers only load on the final RUN bit,
    // so a reset mid-operation never exposes a partial sum.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = acc_next;
                carry_d = fa_c;
                if (last_bit) begin
                    sum_d  = acc_next;
                    cout_d = fa_c;
                    ovf_d  = carry_q ^ fa_c;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8.
`timescale 1ns/1ps
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set and wait for out_valid; lat=99 means a bound expired.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            lat = 99;
            return;
        end
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        lat = out_valid ? n : 99;
    endtask

    task automatic release_op;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fails++;
            $display("FAIL reset_flags: in_ready/out_valid/busy=%b expected 100", {in_ready, out_valid, busy});
        end
        n_checks++;
        if ({sum, cout, ovf} !== 10'h000) begin
            n_fails++;
            $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b expected 00 0 0", sum, cout, ovf);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed;
        logic [7:0] va [5];
        logic [7:0] vb [5];
        logic       vc [5];
        logic [7:0] es [5];
        logic       ec [5];
        logic       eo [5];
        int lat;
        va = '{8'h3C, 8'hFF, 8'h80, 8'h00, 8'h7F};
        vb = '{8'h5A, 8'h01, 8'h80, 8'h00, 8'h00};
        vc = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        es = '{8'h96, 8'h00, 8'h00, 8'h01, 8'h80};
        ec = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        eo = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], lat);
            n_checks++;
            if (lat !== 8) begin
                n_fails++;
                $display("FAIL directed_latency[%0d]: got %0d edges expected 8", i, lat);
            end
            n_checks++;
            if (sum !== es[i]) begin
                n_fails++;
                $display("FAIL directed_sum[%0d]: got %h expected %h", i, sum, es[i]);
            end
            n_checks++;
            if ({cout, ovf} !== {ec[i], eo[i]}) begin
                n_fails++;
                $display("FAIL directed_flags[%0d]: cout/ovf=%b%b expected %b%b", i, cout, ovf, ec[i], eo[i]);
            end
            n_checks++;
            if ({in_ready, busy} !== 2'b00) begin
                n_fails++;
                $display("FAIL directed_done_flags[%0d]: in_ready/busy=%b expected 00", i, {in_ready, busy});
            end
            release_op();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        run_op(8'h12, 8'h34, 1'b0, lat);
        n_checks++;
        if (lat !== 8 || sum !== 8'h46) begin
            n_fails++;
            $display("FAIL bp_first: lat=%0d sum=%h expected 8 46", lat, sum);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = 8'hA0 + 8'(i);
            b = 8'h0F - 8'(i);
            cin = 1'(i);
            tick();
            n_checks++;
            if ({out_valid, in_ready, busy, sum, cout, ovf} !== {3'b100, 8'h46, 2'b00}) begin
                n_fails++;
                $display("FAIL bp_hold[%0d]: v/r/b=%b sum=%h cout=%b ovf=%b expected 100 46 0 0",
                         i, {out_valid, in_ready, busy}, sum, cout, ovf);
            end
        end
        a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_fails++;
            $display("FAIL bp_handoff: v/r/b=%b expected 010", {out_valid, in_ready, busy});
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, busy} !== 2'b01) begin
            n_fails++;
            $display("FAIL bp_accept: in_ready/busy=%b expected 01", {in_ready, busy});
        end
        tick();
        n_checks++;
        if (sum !== 8'h46) begin
            n_fails++;
            $display("FAIL bp_run_hold: sum=%h expected 46", sum);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (!out_valid || sum !== 8'h03 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_second: valid=%b sum=%h cout=%b ovf=%b expected 1 03 0 0", out_valid, sum, cout, ovf);
        end
        release_op();
    endtask

    task automatic test_reset_mid_run;
        int lat;
        a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_run_busy: busy=%b expected 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 8'h00, 2'b00}) begin
            n_fails++;
            $display("FAIL mid_run_reset: r/v/b=%b sum=%h cout=%b ovf=%b expected 100 00 0 0",
                     {in_ready, out_valid, busy}, sum, cout, ovf);
        end
        run_op(8'h01, 8'h01, 1'b0, lat);
        n_checks++;
        if (lat !== 8 || sum !== 8'h02 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_run_fresh: lat=%0d sum=%h cout=%b ovf=%b expected 8 02 0 0", lat, sum, cout, ovf);
        end
        release_op();
    endtask

    task automatic test_back_to_back;
        logic [7:0] xa, xb;
        logic       xc;
        logic [8:0] full;
        logic       exp_ovf;
        logic       hs;
        int n;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            xa = a; xb = b; xc = cin;
            tick();
            n = 0;
            while (!out_valid && n < 40) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
                out_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            full    = {1'b0, xa} + {1'b0, xb} + {8'h00, xc};
            exp_ovf = (xa[7] == xb[7]) && (full[7] != xa[7]);
            n_checks++;
            if (n !== 8 || !out_valid) begin
                n_fails++;
                $display("FAIL b2b_latency[%0d]: got %0d edges expected 8", i, n);
            end
            n_checks++;
            if (sum !== full[7:0]) begin
                n_fails++;
                $display("FAIL b2b_sum[%0d]: %h+%h+%b got %h expected %h", i, xa, xb, xc, sum, full[7:0]);
            end
            n_checks++;
            if ({cout, ovf} !== {full[8], exp_ovf}) begin
                n_fails++;
                $display("FAIL b2b_flags[%0d]: %h+%h+%b cout/ovf=%b%b expected %b%b",
                         i, xa, xb, xc, cout, ovf, full[8], exp_ovf);
            end
            n = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                hs = out_ready;
                tick();
                n++;
            end while (!hs && n < 50);
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
